// File: rtl/logic3_bist.sv
// On-board stimulus/response checker for a 3-input combinational function:
// walks {a,b,c} through 000..111, samples f after a settle delay and compares
// it against EXP_TT. Optional macro LOGIC3_BIST_STOP_ON_FAIL_EN ends a run at
// the first mismatching vector.
module logic3_bist #(
    parameter logic [7:0]  EXP_TT     = 8'hE8,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Wait counter counts SETTLE_CYC-1 down to 0, so SETTLE lasts SETTLE_CYC cycles.
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);

`ifdef LOGIC3_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t     state;
    logic [2:0] idx;
    logic [3:0] wait_cnt;

    logic       mismatch;
    logic [3:0] err_next;
    logic       end_run;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mismatch = 1'b0;
        err_next = err_count;
        end_run  = 1'b0;
        mismatch = (f != EXP_TT[idx]);
        err_next = err_count + {3'b000, mismatch};
        end_run  = (idx == 3'd7) || (STOP_ON_FAIL && mismatch);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            wait_cnt  <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_SETTLE;
                        idx         <= 3'd0;
                        {a, b, c}   <= 3'b000;
                        wait_cnt    <= RELOAD;
                        err_count   <= 4'd0;
                        fail_vec    <= 8'h00;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_SAMPLE: begin
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                        err_count     <= err_next;
                    end
                    if (end_run) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_next == 4'd0);
                        {a, b, c} <= 3'b000;
                    end else begin
                        state     <= S_SETTLE;
                        idx       <= idx + 3'd1;
                        {a, b, c} <= idx + 3'd1;
                        wait_cnt  <= RELOAD;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic3_bist.sv
// Directed bench for logic3_bist: several function models drive f, and each
// run's done timing, busy window, stimulus walk and result registers are checked.
module tb_logic3_bist;

    localparam int SC = 2;
`ifdef LOGIC3_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       f;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    int errors = 0;
    int checks = 0;
    int mode = 0;  // 0 majority, 1 stuck-0, 2 a&b, 3 stuck-1

    logic3_bist #(.EXP_TT(8'hE8), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f(f),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    always_comb begin
        f = 1'b0;
        case (mode)
            0: f = (a & b) | (a & c) | (b & c);
            1: f = 1'b0;
            2: f = a & b;
            default: f = 1'b1;
        endcase
    end

    // Starts a run and observes 40 cycles after the accepting edge (cycle 0).
    task automatic run_watch(input int exp_done, input int restart_at,
                             output int done_at, output int pulses,
                             output bit busy_ok, output bit walk_ok);
        logic [2:0] exp_abc;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_at = -1; pulses = 0; busy_ok = 1'b1; walk_ok = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start = (k == restart_at);
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (busy !== (k < exp_done)) busy_ok = 1'b0;
            exp_abc = (k < exp_done) ? 3'(k / (SC + 1)) : 3'b000;
            if ({a, b, c} !== exp_abc) walk_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic full_run(input string name, input int m, input int exp_done,
                            input int restart_at, input logic exp_pass,
                            input logic [3:0] exp_err, input logic [7:0] exp_fv);
        int done_at, pulses;
        bit busy_ok, walk_ok;
        mode = m;
        run_watch(exp_done, restart_at, done_at, pulses, busy_ok, walk_ok);
        checks++;
        if (done_at !== exp_done) begin
            errors++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_done);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, pulses);
        end
        checks++;
        if (!busy_ok) begin
            errors++; $display("FAIL %s busy_window: got mismatch expected high for %0d cycles", name, exp_done);
        end
        checks++;
        if (!walk_ok) begin
            errors++; $display("FAIL %s abc_walk: got wrong sequence expected vector k/%0d", name, SC + 1);
        end
        checks++;
        if (pass !== exp_pass) begin
            errors++; $display("FAIL %s pass: got %b expected %b", name, pass, exp_pass);
        end
        checks++;
        if (err_count !== exp_err) begin
            errors++; $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_err);
        end
        checks++;
        if (fail_vec !== exp_fv) begin
            errors++; $display("FAIL %s fail_vec: got %h expected %h", name, fail_vec, exp_fv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({a, b, c, busy, done, pass, err_count, fail_vec} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got abc=%b busy=%b done=%b pass=%b err=%0d fv=%h expected all 0",
                     {a, b, c}, busy, done, pass, err_count, fail_vec);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_no_start: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_majority();
        full_run("majority", 0, 24, -1, 1'b1, 4'd0, 8'h00);
    endtask

    task automatic test_stuck0();
        if (STOP) full_run("stuck0", 1, 12, -1, 1'b0, 4'd1, 8'h08);
        else      full_run("stuck0", 1, 24, -1, 1'b0, 4'd4, 8'hE8);
    endtask

    task automatic test_and_fn();
        if (STOP) full_run("and_fn", 2, 12, -1, 1'b0, 4'd1, 8'h08);
        else      full_run("and_fn", 2, 24, -1, 1'b0, 4'd2, 8'h28);
    endtask

    task automatic test_restart_ignored();
        full_run("restart_ignored", 0, 24, 10, 1'b1, 4'd0, 8'h00);
    endtask

    task automatic test_stuck1();
        if (STOP) full_run("stuck1_stop", 3, 3, -1, 1'b0, 4'd1, 8'h01);
        else      full_run("stuck1", 3, 24, -1, 1'b0, 4'd4, 8'h17);
    endtask

    task automatic test_abort();
        int seen_done;
        mode = 2;  // leaves nonzero results mid-run so the reset clear is visible
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ({a, b, c} !== 3'b100 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_precondition: got abc=%b busy=%b expected 100 1", {a, b, c}, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a, b, c, busy, err_count, fail_vec} !== 15'd0) begin
            errors++;
            $display("FAIL abort_async_clear: got abc=%b busy=%b err=%0d fv=%h expected all 0",
                     {a, b, c}, busy, err_count, fail_vec);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done);
        end
        full_run("after_abort", 0, 24, -1, 1'b1, 4'd0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_majority();
        test_stuck0();
        test_and_fn();
        test_restart_ignored();
        test_abort();
        test_stuck1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic3_bist.md
Name: logic3_bist

Overview:
- Synthesizable stimulus/response checker for a 3-input combinational function under test (A, B, C -> f).
- Drives all 8 input combinations in order and samples f after a settle delay.
- Compares each sample against a parameterized expected truth table and reports mismatches.
- Sits beside the lab's combinational function blocks so a function can be checked on-board without a simulator bench.

Parameters:
- EXP_TT, 8'hE8, expected truth table; bit i = expected f for vector i where i = {a,b,c}, a is the MSB (default is 3-input majority).
- SETTLE_CYC, 2, cycles each vector is held before f is sampled; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- f  input  1  output of the function under test
- a  output  1  stimulus A (MSB of vector index)
- b  output  1  stimulus B
- c  output  1  stimulus C (LSB)
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at end of run
- pass  output  1  1 when the last completed run had zero mismatches
- err_count  output  4  number of mismatching vectors in the current/last run (0..8)
- fail_vec  output  8  bit i set when vector i mismatched

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; a=b=c=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; internal index and wait counter = 0. Takes effect immediately, including mid-run; no done pulse is generated for an aborted run.
- All outputs are registered.
- States:
  - IDLE: busy=0. start=1 at a rising edge -> SETTLE with idx=0, {a,b,c}=000, wait counter=SETTLE_CYC-1, err_count=0, fail_vec=0, pass=0.
  - SETTLE: busy=1, {a,b,c}=idx held. Wait counter decrements each cycle; at 0 -> SAMPLE.
  - SAMPLE: busy=1. One cycle; at its closing edge f is compared with EXP_TT[idx].
    - Mismatch: fail_vec[idx]<=1 and err_count<=err_count+1.
    - idx==7 -> DONE; else idx<=idx+1, {a,b,c}<=idx+1, wait counter reloaded -> SETTLE.
  - DONE: busy=0, done=1 for exactly this cycle. pass=(err_count==0) is registered on entry to DONE; {a,b,c}<=000. Next state is IDLE.
- Timing:
  - Each vector occupies SETTLE_CYC+1 cycles.
  - done is asserted 8*(SETTLE_CYC+1) cycles after the edge that accepted start (24 cycles with defaults).
- start while busy or in DONE is ignored; there is no queuing.
- Results (pass, err_count, fail_vec) hold their values in IDLE until the next accepted start or reset.
- err_count saturates naturally at 8 and never wraps; it always equals the popcount of fail_vec.
- f is assumed to be combinationally derived from a, b, c; no synchronizer is required.

Optional Feature:
- Macro: LOGIC3_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE ends the run.
  - Next state is DONE regardless of idx.
  - fail_vec holds only that vector's bit, err_count=1, pass=0.
  - done timing is (idx+1)*(SETTLE_CYC+1) cycles after start acceptance.
- Undefined: all 8 vectors always run, as described above.

Test Plan:
1. Defaults, f driven by a correct majority model, pulse start -> busy high for 24 cycles, done pulses once at cycle 24, pass=1, err_count=0, fail_vec=8'h00, a/b/c walk 000..111.
2. f stuck at 0 -> done at cycle 24, fail_vec=8'hE8, err_count=4, pass=0.
3. f = a&b (wrong function) -> fail_vec=8'h28 (vectors 3 and 5), err_count=2, pass=0.
4. Second start pulse at cycle 10 of a run -> ignored; done still occurs exactly once at cycle 24 and results match scenario 1.
5. rst_n pulled low during vector 4 -> a/b/c/busy/err_count/fail_vec drop to 0 immediately; no done after release; a new start then gives a full clean run.
6. With LOGIC3_BIST_STOP_ON_FAIL_EN defined, f stuck at 1 -> mismatch on vector 0; done at cycle 3, fail_vec=8'h01, err_count=1, pass=0, a/b/c never exceed 000.
